// File: rtl/wb_mul5_slave.sv
// ============================================================================
// Module   : wb_mul5_slave
// Brief    : Wishbone classic responder driving a sequential shift-add multiplier
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mul5_slave #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          OP_W     = 5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o,
    output logic        busy_o
);

    localparam int         c_P_W   = 2 * OP_W;
    localparam int         c_CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CALC  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               r_ack;
    logic [31:0]        r_dat;
    logic               r_irq;
    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic [c_P_W-1:0]   r_product;
    logic               r_done;
    logic               r_irq_en;
    logic [c_P_W-1:0]   r_acc;
    logic [c_P_W-1:0]   r_mcand;
    logic [OP_W-1:0]    r_mplier;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_hit;
    logic               w_acc;
    logic [1:0]         w_reg;
    logic               w_busy;
    logic               w_ctrl_wr;
    logic               w_op_wr;
    logic               w_start;
    logic               w_clr;
    logic               w_last;
    logic               w_done_nxt;
    logic               w_irq_en_nxt;
    logic [c_P_W-1:0]   w_sum;
    logic [31:0]        w_rdata;
    logic               w_unused;

    // An access is taken only on the first cycle of a hit, so a held strobe acks every other cycle
    assign w_hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign w_acc     = w_hit & ~r_ack;
    assign w_reg     = wbs_adr_i[3:2];
    assign w_busy    = (r_state == c_CALC);
    assign w_ctrl_wr = w_acc & wbs_we_i & (w_reg == 2'd0) & wbs_sel_i[0];
    assign w_op_wr   = w_acc & wbs_we_i & (w_reg == 2'd1) & ~w_busy;
    assign w_start   = w_ctrl_wr & wbs_dat_i[0] & ~w_busy;
    assign w_clr     = w_ctrl_wr & wbs_dat_i[2];
    assign w_last    = w_busy & (r_cnt == c_CNT_W'(OP_W - 1));
    assign w_sum     = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign w_unused  = &{1'b0, wbs_dat_i[31:8+OP_W], wbs_dat_i[7:OP_W],
                         wbs_sel_i[3:2], wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_state_nxt = c_CALC;
            c_CALC:  if (w_last)  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Completion beats a simultaneous clear; a start beats both
    always_comb begin
        w_done_nxt = r_done;
        if (w_start) begin
            w_done_nxt = 1'b0;
        end else if (w_last) begin
            w_done_nxt = 1'b1;
        end else if (w_clr) begin
            w_done_nxt = 1'b0;
        end
        w_irq_en_nxt = w_ctrl_wr ? wbs_dat_i[1] : r_irq_en;
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            2'd0: begin
                w_rdata[0] = w_busy;
                w_rdata[1] = r_irq_en;
                w_rdata[2] = r_done;
            end
            2'd1: begin
                w_rdata[OP_W-1:0]   = r_a;
                w_rdata[8+:OP_W]    = r_b;
            end
            2'd2:    w_rdata[c_P_W-1:0] = r_product;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_irq     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
            r_irq_en  <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
        end else begin
            r_ack    <= w_acc;
            r_dat    <= w_acc ? w_rdata : 32'd0;
            r_done   <= w_done_nxt;
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= w_done_nxt & w_irq_en_nxt;

            if (w_op_wr && wbs_sel_i[0]) r_a <= wbs_dat_i[OP_W-1:0];
            if (w_op_wr && wbs_sel_i[1]) r_b <= wbs_dat_i[8+:OP_W];

            if (w_start) begin
                r_acc    <= '0;
                r_mcand  <= {{OP_W{1'b0}}, r_a};
                r_mplier <= r_b;
                r_cnt    <= '0;
            end else if (w_busy) begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_CNT_W'(1);
                if (w_last) r_product <= w_sum;
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_irq;
    assign busy_o    = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_wb_mul5_slave.sv
// ============================================================================
// Module   : tb_wb_mul5_slave
// Brief    : Self-checking bench for wb_mul5_slave against a register-level model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_mul5_slave;

    localparam logic [31:0] c_BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat = 32'h0;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Register-level model: operands, latched operands, product, flags, cycles left in the multiply
    int          m_busy_left;
    logic [4:0]  m_a, m_b, m_la, m_lb;
    logic [9:0]  m_prod;
    bit          m_done, m_irq_en, m_ack;

    logic [31:0] last_rd;
    bit          last_ack;
    int          cur_run, last_run;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [9:0] p;
    } vec_t;
    vec_t vecs[7];

    wb_mul5_slave #(.BASE_ADR(c_BASE), .OP_W(5)) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .irq_o     (irq),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy_left = 0;
        m_a = 0; m_b = 0; m_la = 0; m_lb = 0; m_prod = 0;
        m_done = 0; m_irq_en = 0; m_ack = 0;
        cur_run = 0;
    endtask

    // One clock: predict the edge from the bus inputs, then compare every output after it
    task automatic tick();
        bit          hit, acc, pre_busy, fin, start, clr;
        logic [1:0]  rs;
        logic [31:0] exp_rd;
        hit      = cyc && stb && (adr[31:4] == c_BASE[31:4]);
        acc      = hit && !m_ack;
        pre_busy = (m_busy_left > 0);
        fin      = (m_busy_left == 1);
        rs       = adr[3:2];
        exp_rd   = 32'd0;
        start    = 0;
        clr      = 0;
        if (acc) begin
            case (rs)
                2'd0: exp_rd = {29'd0, m_done, m_irq_en, pre_busy};
                2'd1: exp_rd = {19'd0, m_b, 3'd0, m_a};
                2'd2: exp_rd = {22'd0, m_prod};
                default: exp_rd = 32'd0;
            endcase
        end
        if (acc && we) begin
            if (rs == 2'd1 && !pre_busy) begin
                if (sel[0]) m_a = dat[4:0];
                if (sel[1]) m_b = dat[12:8];
            end
            if (rs == 2'd0 && sel[0]) begin
                m_irq_en = dat[1];
                start    = dat[0] && !pre_busy;
                clr      = dat[2];
            end
        end
        if (m_busy_left > 0) m_busy_left--;
        if (fin) begin
            m_done = 1;
            m_prod = 10'(m_la) * 10'(m_lb);
        end else if (start) begin
            m_busy_left = 5;
            m_done = 0;
            m_la = m_a;
            m_lb = m_b;
        end else if (clr) begin
            m_done = 0;
        end
        m_ack = acc;
        @(posedge clk);
        #1;
        chk("ack", {31'd0, ack}, {31'd0, m_ack});
        chk("rdata", dat_o, exp_rd);
        chk("busy", {31'd0, busy}, {31'd0, m_busy_left > 0});
        chk("irq", {31'd0, irq}, {31'd0, m_done && m_irq_en});
        last_rd  = dat_o;
        last_ack = ack;
        if (busy) cur_run++;
        else if (cur_run > 0) begin
            last_run = cur_run;
            cur_run  = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drop();
        cyc = 0; stb = 0; we = 0; sel = 0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
        cyc = 1; stb = 1; we = 1; adr = c_BASE + {28'd0, off}; dat = d; sel = s;
        tick();
        drop();
        tick();
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        cyc = 1; stb = 1; we = 0; adr = c_BASE + {28'd0, off}; sel = 4'hF;
        tick();
        d = last_rd;
        drop();
        tick();
    endtask

    task automatic do_reset();
        drop();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1;
    endtask

    initial begin
        logic [31:0] rdv;
        logic [3:0]  pat;
        int          nack;

        vecs[0] = '{5'd31, 5'd31, 10'd961};
        vecs[1] = '{5'd0,  5'd31, 10'd0};
        vecs[2] = '{5'd1,  5'd1,  10'd1};
        vecs[3] = '{5'd16, 5'd2,  10'd32};
        vecs[4] = '{5'd21, 5'd10, 10'd210};
        vecs[5] = '{5'd31, 5'd1,  10'd31};
        vecs[6] = '{5'd7,  5'd9,  10'd63};

        model_reset();
        last_run = 0;
        do_reset();

        rd(4'h0, rdv); chk("rst_rd_ctrl", rdv, 32'd0);
        rd(4'h4, rdv); chk("rst_rd_ops", rdv, 32'd0);
        rd(4'h8, rdv); chk("rst_rd_res", rdv, 32'd0);

        // Held strobe: ack must alternate
        cyc = 1; stb = 1; we = 0; adr = c_BASE; sel = 4'hF;
        pat = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pat = {pat[2:0], last_ack};
        end
        drop(); tick();
        chk("held_stb_ack", {28'd0, pat}, 32'h0000_000A);

        wr(4'h4, 32'h0A15, 4'hF);
        wr(4'h0, 32'h1, 4'h1);
        idle(6);
        chk("busy_len", last_run, 5);
        rd(4'h8, rdv); chk("mul_21x10", rdv, 32'd210);
        rd(4'h0, rdv); chk("ctrl_done", rdv, 32'h4);

        foreach (vecs[i]) begin
            wr(4'h4, {19'd0, vecs[i].b, 3'd0, vecs[i].a}, 4'h3);
            wr(4'h0, 32'h1, 4'h1);
            idle(4);
            rd(4'h8, rdv);
            chk($sformatf("vec%0d", i), rdv, {22'd0, vecs[i].p});
        end

        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                wr(4'h4, (b << 8) | a, 4'h3);
                wr(4'h0, 32'h1, 4'h1);
                idle(4);
                rd(4'h8, rdv);
                chk("sweep", rdv, a * b);
            end
        end

        wr(4'h4, 32'h0303, 4'h3);
        wr(4'h4, 32'h1F1F, 4'h1);
        rd(4'h4, rdv); chk("byte_en_ops", rdv, 32'h031F);
        wr(4'h0, 32'h1, 4'h1);
        idle(4);
        rd(4'h8, rdv); chk("byte_en_res", rdv, 32'd93);

        wr(4'h4, 32'h0A15, 4'h3);
        wr(4'h0, 32'h1, 4'h1);
        wr(4'h4, 32'h0101, 4'h3);
        wr(4'h0, 32'h1, 4'h1);
        idle(4);
        rd(4'h8, rdv); chk("busy_prot_res", rdv, 32'd210);
        rd(4'h4, rdv); chk("busy_prot_ops", rdv, 32'h0A15);
        chk("busy_after", {31'd0, busy}, 32'd0);

        // Start with clear in one write: start wins
        wr(4'h0, 32'h5, 4'h1);
        rd(4'h0, rdv); chk("start_beats_clr", rdv, 32'h1);
        idle(4);
        // Clear landing on the completion edge: set wins
        wr(4'h0, 32'h1, 4'h1);
        idle(3);
        wr(4'h0, 32'h4, 4'h1);
        rd(4'h0, rdv); chk("set_beats_clr", rdv, 32'h4);

        wr(4'h4, 32'h0503, 4'h3);
        wr(4'h0, 32'h3, 4'h1);
        idle(4);
        chk("irq_rise", {31'd0, irq}, 32'd1);
        rd(4'h8, rdv); chk("mul_3x5", rdv, 32'd15);
        cyc = 1; stb = 1; we = 1; adr = c_BASE; dat = 32'h6; sel = 4'h1;
        tick();
        chk("irq_clr", {31'd0, irq}, 32'd0);
        drop(); tick();
        rd(4'h0, rdv); chk("ctrl_after_clr", rdv, 32'h2);

        cyc = 1; stb = 1; we = 0; adr = c_BASE + 32'h10; sel = 4'hF;
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_ack) nack++;
        end
        drop(); tick();
        chk("miss_no_ack", nack, 0);

        // Reset in the middle of a multiply
        wr(4'h4, 32'h0707, 4'h3);
        wr(4'h0, 32'h1, 4'h1);
        idle(1);
        do_reset();
        rd(4'h8, rdv); chk("abort_res", rdv, 32'd0);
        rd(4'h0, rdv); chk("abort_ctrl", rdv, 32'd0);

        for (int n = 0; n < 400; n++) begin
            int r;
            r   = $urandom_range(0, 9);
            cyc = 1; stb = 1;
            we  = $urandom_range(0, 1);
            sel = 4'($urandom);
            dat = (r < 5) ? 32'($urandom_range(0, 7)) : $urandom;
            adr = (r == 9) ? (c_BASE + 32'h10 + 32'($urandom_range(0, 3) * 4))
                           : (c_BASE + 32'($urandom_range(0, 3) * 4));
            tick();
            drop();
            tick();
            idle($urandom_range(0, 3));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
